// File: rtl/window_buffer_3x3_pkg.sv
// rtl/window_buffer_3x3_pkg.sv - shared pixel type, window tap indices and window FSM states
// Purpose : common definitions for the 3x3 window buffer, the pipeline controller and conv3x3.
// Contents: PIX_W / pix_t pixel type, WIN_TL..WIN_BR tap indices, window state enum.
package window_buffer_3x3_pkg;

   localparam int PIX_W = 8;
   typedef logic signed [PIX_W-1:0] pix_t;

   // Tap indices into a 3x3 window, row-major, top-left first; WIN_BR is the newest pixel.
   localparam int WIN_TL   = 0;
   localparam int WIN_TC   = 1;
   localparam int WIN_TR   = 2;
   localparam int WIN_ML   = 3;
   localparam int WIN_MC   = 4;
   localparam int WIN_MR   = 5;
   localparam int WIN_BL   = 6;
   localparam int WIN_BC   = 7;
   localparam int WIN_BR   = 8;
   localparam int WIN_TAPS = 9;

   typedef enum logic {
      WIN_EMPTY = 1'b0,
      WIN_FULL  = 1'b1
   } win_state_e;

endpackage

// File: rtl/window_buffer_3x3_if.sv
// rtl/window_buffer_3x3_if.sv - pixel-in / window-out handshake bundle
// Purpose : groups the pixel stream input and the 3x3 window output of window_buffer_3x3.
// Signals : pix_valid/pix_ready/pix_data (pixel stream), win_valid_out/win_ready/win_data0..8
//           (window stream), frame_done (end-of-frame pulse).
// Modports: master = producer of pixels and consumer of windows; slave = the window buffer.
interface window_buffer_3x3_if #(
   parameter int DATA_W = 8
);
   logic                     pix_valid;
   logic                     pix_ready;
   logic signed [DATA_W-1:0] pix_data;
   logic                     win_valid_out;
   logic                     win_ready;
   logic signed [DATA_W-1:0] win_data0;
   logic signed [DATA_W-1:0] win_data1;
   logic signed [DATA_W-1:0] win_data2;
   logic signed [DATA_W-1:0] win_data3;
   logic signed [DATA_W-1:0] win_data4;
   logic signed [DATA_W-1:0] win_data5;
   logic signed [DATA_W-1:0] win_data6;
   logic signed [DATA_W-1:0] win_data7;
   logic signed [DATA_W-1:0] win_data8;
   logic                     frame_done;

   modport master (
      output pix_valid, pix_data, win_ready,
      input  pix_ready, win_valid_out, frame_done,
      input  win_data0, win_data1, win_data2, win_data3, win_data4,
      input  win_data5, win_data6, win_data7, win_data8
   );

   modport slave (
      input  pix_valid, pix_data, win_ready,
      output pix_ready, win_valid_out, frame_done,
      output win_data0, win_data1, win_data2, win_data3, win_data4,
      output win_data5, win_data6, win_data7, win_data8
   );
endinterface

// File: rtl/window_buffer_3x3_line_buffer.sv
// rtl/window_buffer_3x3_line_buffer.sv - one-row pixel store, read-before-write
// Purpose : holds one image row; dout shows the stored pixel at addr, so a write on the same
//           edge returns the previous row's value to the reader.
// Ports   : clk, rst (sync, active-high, clears the store), en (write strobe),
//           addr (column), din (pixel in), dout (stored pixel at addr).
module window_buffer_3x3_line_buffer #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 8,
   parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [AW-1:0]            addr,
   input  logic signed [DATA_W-1:0] din,
   output logic signed [DATA_W-1:0] dout
);
   logic signed [DATA_W-1:0] mem_q [DEPTH];

   assign dout = mem_q[addr];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (en) begin
         mem_q[addr] <= din;
      end
   end
endmodule

// File: rtl/window_buffer_3x3.sv
// rtl/window_buffer_3x3.sv - raster pixel stream to 3x3 sliding windows
// Purpose : two line buffers plus a 3x3 register window turn a raster-order signed pixel stream
//           into 3x3 windows; windows back-pressure the pixel input.
// Ports   : clk, rst (sync, active-high), bus (window_buffer_3x3_if.slave: pixel stream in,
//           window stream out, frame_done pulse).
// Config  : WIN_STRIDE2_EN defined -> windows only at even row and even column (stride 2);
//           undefined -> stride 1.
module window_buffer_3x3
   import window_buffer_3x3_pkg::*;
#(
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int DATA_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   window_buffer_3x3_if.slave   bus
);
   localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   logic [CW-1:0]            col_q;
   logic [RW-1:0]            row_q;
   logic signed [DATA_W-1:0] win_q [WIN_TAPS];
   win_state_e               state_q;
   logic                     frame_done_q;

   logic                     pix_fire;
   logic                     qualify;
   logic                     col_last;
   logic                     row_last;
   logic signed [DATA_W-1:0] lb0_dout;
   logic signed [DATA_W-1:0] lb1_dout;

   assign bus.pix_ready = (state_q == WIN_EMPTY) | bus.win_ready;
   assign pix_fire      = bus.pix_valid & bus.pix_ready;
   assign col_last      = (col_q == COL_LAST);
   assign row_last      = (row_q == ROW_LAST);

   // Only positions whose full 3x3 neighbourhood lies in the current row band produce a window,
   // which also keeps stale line-buffer contents from a previous frame hidden.
`ifdef WIN_STRIDE2_EN
   assign qualify = (row_q >= RW'(2)) && (col_q >= CW'(2)) && !row_q[0] && !col_q[0];
`else
   assign qualify = (row_q >= RW'(2)) && (col_q >= CW'(2));
`endif

   // lb0 holds row r-1, lb1 holds row r-2; lb1 is refilled from lb0's old value.
   window_buffer_3x3_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(CW)) lb0 (
      .clk  (clk),
      .rst  (rst),
      .en   (pix_fire),
      .addr (col_q),
      .din  (bus.pix_data),
      .dout (lb0_dout)
   );

   window_buffer_3x3_line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W), .AW(CW)) lb1 (
      .clk  (clk),
      .rst  (rst),
      .en   (pix_fire),
      .addr (col_q),
      .din  (lb0_dout),
      .dout (lb1_dout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= WIN_EMPTY;
         frame_done_q <= 1'b0;
         col_q        <= '0;
         row_q        <= '0;
         for (int i = 0; i < WIN_TAPS; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         frame_done_q <= pix_fire && col_last && row_last;

         if (pix_fire) begin
            win_q[WIN_TL] <= win_q[WIN_TC];
            win_q[WIN_TC] <= win_q[WIN_TR];
            win_q[WIN_TR] <= lb1_dout;
            win_q[WIN_ML] <= win_q[WIN_MC];
            win_q[WIN_MC] <= win_q[WIN_MR];
            win_q[WIN_MR] <= lb0_dout;
            win_q[WIN_BL] <= win_q[WIN_BC];
            win_q[WIN_BC] <= win_q[WIN_BR];
            win_q[WIN_BR] <= bus.pix_data;

            if (col_last) begin
               col_q <= '0;
               row_q <= row_last ? '0 : row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end

         // A pixel is only accepted in FULL when the window is being taken the same cycle,
         // so the held window is never overwritten.
         case (state_q)
            WIN_EMPTY: if (pix_fire && qualify) state_q <= WIN_FULL;
            WIN_FULL: begin
               if (pix_fire && qualify) state_q <= WIN_FULL;
               else if (bus.win_ready)  state_q <= WIN_EMPTY;
            end
            default:                    state_q <= WIN_EMPTY;
         endcase
      end
   end

   assign bus.win_valid_out = (state_q == WIN_FULL);
   assign bus.frame_done    = frame_done_q;
   assign bus.win_data0     = win_q[WIN_TL];
   assign bus.win_data1     = win_q[WIN_TC];
   assign bus.win_data2     = win_q[WIN_TR];
   assign bus.win_data3     = win_q[WIN_ML];
   assign bus.win_data4     = win_q[WIN_MC];
   assign bus.win_data5     = win_q[WIN_MR];
   assign bus.win_data6     = win_q[WIN_BL];
   assign bus.win_data7     = win_q[WIN_BC];
   assign bus.win_data8     = win_q[WIN_BR];
endmodule
